// File: rtl/cpu_pio_in_edge_if.sv
// Avalon-MM register bus between the CPU fabric and the input PIO slave.
// The master drives the address/strobe/data; the slave returns registered readdata.
interface cpu_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/cpu_pio_in_edge.sv
// Multi-channel input PIO: synchroniser, debouncer and edge detector per channel,
// sticky W1C edge capture, interrupt mask and a level irq to the CPU.
module cpu_pio_in_edge #(
  parameter int WIDTH           = 4,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IRQ_ON_EDGE     = 1
) (
  input  logic               clk,
  input  logic               reset,
  cpu_pio_in_edge_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  localparam bit            BYPASS  = (DEBOUNCE_CYCLES <= 1);
  localparam int            CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = BYPASS ? {CW{1'b0}} : CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] event_s, clr_s;
  logic             wr_s;

  assign wr_s = bus.chipselect && !bus.write_n;

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd_s;
    assign unused_wd_s = ^bus.writedata[31:WIDTH];
  end

  // Debouncer: a new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = {CW{1'b0}};
      if (BYPASS) begin
        stable_d[i] = sync2_q[i];
      end else if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Edge selection; the reserved mode falls back to "any edge".
  always_comb begin
    case (EDGE_MODE)
      0:       event_s = stable_q & ~prev_q;
      1:       event_s = ~stable_q & prev_q;
      default: event_s = stable_q ^ prev_q;
    endcase
  end

  // Register writes: W1C on capture (a same-cycle set wins), plain write on mask.
  always_comb begin
    if (wr_s && (bus.address == 2'd3)) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    cap_d = (cap_q & ~clr_s) | event_s;
    if (wr_s && (bus.address == 2'd2)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
  end

  // Read mux, sampled every cycle irrespective of chipselect.
  always_comb begin
    case (bus.address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(cap_q);
      default: readdata_d = 32'd0;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= {WIDTH{1'b0}};
      sync2_q    <= {WIDTH{1'b0}};
      stable_q   <= {WIDTH{1'b0}};
      prev_q     <= {WIDTH{1'b0}};
      mask_q     <= {WIDTH{1'b0}};
      cap_q      <= {WIDTH{1'b0}};
      readdata_q <= 32'd0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.readdata = readdata_q;
  // irq comes from registered state only, never straight from in_port.
  assign irq = (IRQ_ON_EDGE != 0) ? |(cap_q & mask_q) : |(stable_q & mask_q);

endmodule

// File: tb/tb_cpu_pio_in_edge.sv
// Bench: several parameter sets of cpu_pio_in_edge share one bus and input stimulus;
// each instance is compared every cycle against a window-based behavioural model.
module tb_cpu_pio_in_edge;

  localparam int NCFG = 6;
  localparam int CFG_W    [NCFG] = '{4, 4, 4, 4, 4, 32};
  localparam int CFG_EM   [NCFG] = '{0, 0, 1, 2, 3, 2};
  localparam int CFG_D    [NCFG] = '{1, 16, 4, 4, 2, 3};
  localparam int CFG_IRQE [NCFG] = '{1, 1, 1, 1, 0, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = 32'd0;
  logic [31:0] in_all = 32'd0;
  logic        chk_en = 1'b0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W    = CFG_W[g];
    localparam int EM   = CFG_EM[g];
    localparam int D    = CFG_D[g];
    localparam int IRQE = CFG_IRQE[g];
    localparam int DM   = (D > 1) ? D : 1;

    cpu_pio_in_edge_if bus_if ();
    logic [W-1:0] in_s;
    logic         irq_s;

    assign bus_if.address    = address;
    assign bus_if.chipselect = cs;
    assign bus_if.write_n    = wn;
    assign bus_if.writedata  = wd;
    assign in_s              = in_all[W-1:0];

    cpu_pio_in_edge #(
      .WIDTH(W), .EDGE_MODE(EM), .DEBOUNCE_CYCLES(D), .IRQ_ON_EDGE(IRQE)
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if.slave),
      .in_port(in_s),
      .irq    (irq_s)
    );

    // Reference model: a level is accepted once the last D synchronised samples all differ from it.
    logic [W-1:0] s1_q, s2_q, stab_q, prev_q, cap_q, mask_q;
    logic [W-1:0] hist_q [DM];
    int           hv_q;
    logic [31:0]  rd_q, rd_n;
    logic [W-1:0] stab_n, ev_n, clr_n, all_diff, cap_n, mask_n;
    logic         exp_irq;

    always_comb begin
      all_diff = s2_q ^ stab_q;
      for (int k = 0; k < D - 1; k++) all_diff = all_diff & (hist_q[k] ^ stab_q);
      if (D <= 1) stab_n = s2_q;
      else if (hv_q >= D - 1) stab_n = stab_q ^ all_diff;
      else stab_n = stab_q;
      if (EM == 0) ev_n = stab_q & ~prev_q;
      else if (EM == 1) ev_n = ~stab_q & prev_q;
      else ev_n = stab_q ^ prev_q;
      clr_n  = (cs && !wn && address == 2'd3) ? wd[W-1:0] : '0;
      mask_n = (cs && !wn && address == 2'd2) ? wd[W-1:0] : mask_q;
      cap_n  = (cap_q & ~clr_n) | ev_n;
      case (address)
        2'd0:    rd_n = 32'(stab_q);
        2'd2:    rd_n = 32'(mask_q);
        2'd3:    rd_n = 32'(cap_q);
        default: rd_n = 32'd0;
      endcase
      exp_irq = (IRQE != 0) ? |(cap_q & mask_q) : |(stab_q & mask_q);
    end

    always @(posedge clk) begin
      if (reset) begin
        s1_q <= '0; s2_q <= '0; stab_q <= '0; prev_q <= '0;
        cap_q <= '0; mask_q <= '0; rd_q <= '0; hv_q <= 0;
        for (int k = 0; k < DM; k++) hist_q[k] <= '0;
      end else begin
        s1_q   <= in_s;
        s2_q   <= s1_q;
        stab_q <= stab_n;
        prev_q <= stab_q;
        cap_q  <= cap_n;
        mask_q <= mask_n;
        rd_q   <= rd_n;
        hist_q[0] <= s2_q;
        for (int k = 1; k < DM; k++) hist_q[k] <= hist_q[k-1];
        hv_q <= (hv_q < D) ? hv_q + 1 : hv_q;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check_eq($sformatf("g%0d_readdata", g), bus_if.readdata, rd_q);
        check_eq($sformatf("g%0d_irq", g), 32'(irq_s), 32'(exp_irq));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; wd = d; cs = 1'b1; wn = 1'b0;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1;
  endtask

  initial begin
    int hold;
    cycles(3);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state on every address
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      cycles(1);
      check_eq("rst_readdata", g_cfg[0].bus_if.readdata, 32'd0);
      check_eq("rst_irq", 32'(g_cfg[0].irq_s), 32'd0);
    end

    // Bypass instance: rising edge on bit 0, capture at edge 3
    bus_write(2'd2, 32'h5);
    address = 2'd3;
    in_all = 32'h1;
    cycles(3);
    check_eq("byp_irq_e2", 32'(g_cfg[0].irq_s), 32'd0);
    cycles(1);
    check_eq("byp_irq_e3", 32'(g_cfg[0].irq_s), 32'd1);
    cycles(1);
    check_eq("byp_cap", g_cfg[0].bus_if.readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    check_eq("byp_w1c_irq", 32'(g_cfg[0].irq_s), 32'd0);

    // Debounce (D=16): glitch rejected, long pulse accepted
    cycles(30);
    bus_write(2'd3, 32'hFFFF_FFFF);
    cycles(1);
    check_eq("db_clr", g_cfg[1].bus_if.readdata, 32'h0);
    address = 2'd0;
    in_all = 32'h5;
    cycles(10);
    in_all = 32'h1;
    cycles(30);
    check_eq("db_glitch_data", g_cfg[1].bus_if.readdata, 32'h1);
    check_eq("db_glitch_irq", 32'(g_cfg[1].irq_s), 32'd0);
    address = 2'd3;
    cycles(1);
    check_eq("db_glitch_cap", g_cfg[1].bus_if.readdata, 32'h0);
    address = 2'd0;
    in_all = 32'h5;
    cycles(18);
    check_eq("db_irq_e17", 32'(g_cfg[1].irq_s), 32'd0);
    cycles(1);
    check_eq("db_irq_e18", 32'(g_cfg[1].irq_s), 32'd1);
    check_eq("db_data_e18", g_cfg[1].bus_if.readdata, 32'h5);
    cycles(21);
    in_all = 32'h1;
    cycles(30);

    // Collision: W1C of bit 1 on the edge that sets it
    bus_write(2'd2, 32'h2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_all = 32'h3;
    cycles(3);
    bus_write(2'd3, 32'h2);
    check_eq("col_irq", 32'(g_cfg[0].irq_s), 32'd1);
    cycles(1);
    check_eq("col_cap", g_cfg[0].bus_if.readdata & 32'h2, 32'h2);

    // Masked capture, then unmask
    bus_write(2'd2, 32'h0);
    cycles(30);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_all = 32'hB;
    cycles(40);
    check_eq("msk_cap", g_cfg[0].bus_if.readdata, 32'h8);
    check_eq("msk_irq", 32'(g_cfg[0].irq_s), 32'd0);
    bus_write(2'd2, 32'h8);
    check_eq("unmask_irq", 32'(g_cfg[0].irq_s), 32'd1);

    // Falling-only and any-edge modes
    address = 2'd3;
    cycles(1);
    check_eq("fall_rise_none", g_cfg[2].bus_if.readdata, 32'h0);
    check_eq("any_rise", g_cfg[3].bus_if.readdata, 32'h8);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_all = 32'h3;
    cycles(20);
    check_eq("fall_set", g_cfg[2].bus_if.readdata, 32'h8);
    check_eq("any_fall", g_cfg[3].bus_if.readdata, 32'h8);

    // Level interrupt mode follows data & mask
    check_eq("lvl_irq_lo", 32'(g_cfg[4].irq_s), 32'd0);
    in_all = 32'hB;
    cycles(20);
    check_eq("lvl_irq_hi", 32'(g_cfg[4].irq_s), 32'd1);
    bus_write(2'd2, 32'h0);
    check_eq("lvl_mask_off", 32'(g_cfg[4].irq_s), 32'd0);

    // Reset in the middle of a debounce count
    in_all = 32'h0;
    cycles(40);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_all = 32'h1;
    cycles(8);
    reset = 1'b1;
    in_all = 32'h0;
    cycles(1);
    reset = 1'b0;
    cycles(40);
    check_eq("mid_rst_cap", g_cfg[1].bus_if.readdata, 32'h0);
    check_eq("mid_rst_irq", 32'(g_cfg[1].irq_s), 32'd0);

    // Randomised traffic against the models
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) in_all = $urandom;
        else in_all = in_all ^ (32'h1 << $urandom_range(0, 31));
        hold = $urandom_range(1, 40);
      end
      hold--;
      cs      = ($urandom_range(0, 3) == 0);
      wn      = ($urandom_range(0, 1) == 0);
      address = 2'($urandom_range(0, 3));
      wd      = $urandom;
      reset   = ($urandom_range(0, 999) == 0);
      cycles(1);
    end
    reset = 1'b0;
    cs = 1'b0;
    wn = 1'b1;
    cycles(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
